bit_serial_adder: RTL and testbench
===================================

// Module: bit_serial_adder
//
// PURPOSE
//   Multi-bit adder built around a single full-adder stage, used LSB first,
//   one bit per clock. A carry flip-flop feeds each stage's carry-out back
//   into the next bit's carry-in. Operands and carry-in are loaded in parallel.
//   Result is returned in parallel with carry-out and signed overflow.
//   Sits between operand registers and the datapath. Trades WIDTH cycles of
//   latency for one full-adder cell.
//
// PARAMETERS
//   WIDTH   8   operand/result width in bits; legal range 2..64
//
// PORTS
//   clk     in   1      single clock; all state updates on rising edge
//   rst_n   in   1      asynchronous, active-low reset
//   start   in   1      request; sampled only in IDLE
//   a       in   WIDTH  operand A; captured on the accepting edge
//   b       in   WIDTH  operand B; captured on the accepting edge
//   cin     in   1      carry-in; captured on the accepting edge
//   busy    out  1      high while an addition is in progress
//   done    out  1      one-cycle pulse; sum/cout/ovf valid from this cycle
//   sum     out  WIDTH  a + b + cin, modulo 2^WIDTH
//   cout    out  1      carry out of bit WIDTH-1
//   ovf     out  1      signed overflow = carry into MSB ^ carry out of MSB
//
// BEHAVIOUR
//   Reset (rst_n low, takes effect immediately, no clock needed):
//   - state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0.
//   - Internal shift registers, carry FF and bit counter all cleared.
//   - An addition in flight is discarded; it is never completed.
//   FSM states: IDLE, RUN.
//   IDLE:
//   - If start=1 at an edge: load a_sr<=a, b_sr<=b, c<=cin, cnt<=0, busy<=1.
//   - Go to RUN. That edge is the accepting edge (edge 0).
//   - If start=0: hold. sum/cout/ovf keep their last result.
//   RUN, every edge:
//   - s = a_sr[0]^b_sr[0]^c.
//   - c <= (a_sr[0]&b_sr[0]) | (c&(a_sr[0]^b_sr[0])).
//   - a_sr and b_sr shift right by one; s shifts into the MSB of s_sr.
//   - cnt increments.
//   RUN, edge where cnt==WIDTH-1 (edge WIDTH after acceptance):
//   - Last bit is added.
//   - sum <= final s_sr, including this cycle's s.
//   - cout <= new carry.
//   - ovf <= c ^ new carry (c here is the carry into the MSB).
//   - done<=1, busy<=0, state<=IDLE.
//   Latency:
//   - done is high in the cycle following edge WIDTH, exactly one cycle.
//   - busy is high for exactly WIDTH cycles.
//   Outputs:
//   - sum/cout/ovf change only at completion or reset.
//   - Never show intermediate values.
//   start in RUN: ignored; not queued; operand changes have no effect.
//   Back-to-back:
//   - start may be high in the done cycle (state is IDLE), and is accepted.
//   - Throughput is one result per WIDTH cycles.
//   - The new operation does not disturb the sum just presented.
//   Counter width: $clog2(WIDTH). cnt is never compared beyond WIDTH-1.
//   No wrap is reachable.
//   Arithmetic:
//   - Unsigned result is {cout,sum}.
//   - ovf is meaningful for two's-complement operands.
//
// TESTING (WIDTH=8)
//   1. a=00, b=00, cin=0, start -> done 8 cycles later; sum=00, cout=0, ovf=0;
//      busy high exactly 8 cycles.
//   2. a=FF, b=01, cin=0 -> sum=00, cout=1, ovf=0 (carry ripples all 8 bits).
//   3. a=7F, b=01, cin=0 -> sum=80, cout=0, ovf=1;
//      a=80, b=FF -> sum=7F, cout=1, ovf=1.
//   4. a=AA, b=55, cin=1 -> sum=00, cout=1, ovf=0;
//      then start held high in the done cycle with a=03, b=04 ->
//      next done gives sum=07.
//   5. start with a=10, b=20; pulse start again at RUN cycle 3 with a=FF,
//      b=FF -> second request ignored; single done, sum=30; no further done.
//   6. rst_n low during RUN cycle 4 (a=F0, b=0F) -> busy/done/sum/cout/ovf=0
//      immediately, with no done pulse; after release, a=01, b=02 -> sum=03.

Source files
------------

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: one full-adder cell reused LSB first, one bit per clock.
// Operands load in parallel; sum, carry-out and signed overflow return in parallel.
module bit_serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             bit_s;
  logic             carry_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    bit_s   = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
    carry_n = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        s_sr_d = {bit_s, s_sr_q[WIDTH-1:1]};
        c_d    = carry_n;
        cnt_d  = cnt_q + CNT_W'(1);
        // On the MSB step c_q is the carry into the MSB, so ovf is its XOR with carry-out.
        if (cnt_q == LAST) begin
          sum_d   = s_sr_d;
          cout_d  = carry_n;
          ovf_d   = c_q ^ carry_n;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder: directed cases with literal results
// plus randomized operations compared every cycle against an arithmetic model.
module tb_bit_serial_adder;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks = 0;
  int errors = 0;

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted request completes W edges later with plain arithmetic.
  logic         m_busy, m_done, m_cout, m_ovf;
  logic [W-1:0] m_sum;
  int           m_left;
  logic [W-1:0] pa, pb;
  logic         pc;

  always @(posedge clk or negedge rst_n) begin
    longint unsigned total;
    longint          stotal;
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          total  = longint'(pa) + longint'(pb) + longint'(pc);
          stotal = longint'($signed(pa)) + longint'($signed(pb)) + longint'(pc);
          m_sum  = total[W-1:0];
          m_cout = total[W];
          m_ovf  = (stotal > ((64'sd1 <<< (W-1)) - 1)) || (stotal < -(64'sd1 <<< (W-1)));
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        pa = a; pb = b; pc = cin;
        m_left = W;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("busy_vs_model", busy, m_busy);
    check("done_vs_model", done, m_done);
    check("sum_vs_model",  sum,  m_sum);
    check("cout_vs_model", cout, m_cout);
    check("ovf_vs_model",  ovf,  m_ovf);
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    @(posedge clk); #2;
    start = 1'b1; a = av; b = bv; cin = cv;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit found, output int busy_cycles);
    found = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    check("done_within_budget", found, 1);
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] es,
                               input logic ec, input logic eo);
    check({name, "_sum"},  sum,  es);
    check({name, "_cout"}, cout, ec);
    check({name, "_ovf"},  ovf,  eo);
  endtask

  initial begin
    bit found;
    int bc;
    int extra;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    #12;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sum",  sum,  0);
    #5 rst_n = 1'b1;

    // 1: zero operands, busy for exactly W cycles
    issue(8'h00, 8'h00, 1'b0);
    wait_done(found, bc);
    check("t1_busy_cycles", bc, 8);
    expect_result("t1", 8'h00, 1'b0, 1'b0);

    // 2: carry ripples through every bit
    issue(8'hFF, 8'h01, 1'b0);
    wait_done(found, bc);
    expect_result("t2", 8'h00, 1'b1, 1'b0);

    // 3: signed overflow, both directions
    issue(8'h7F, 8'h01, 1'b0);
    wait_done(found, bc);
    expect_result("t3a", 8'h80, 1'b0, 1'b1);
    issue(8'h80, 8'hFF, 1'b0);
    wait_done(found, bc);
    expect_result("t3b", 8'h7F, 1'b1, 1'b1);

    // 4: carry-in, then back-to-back start during the done cycle
    issue(8'hAA, 8'h55, 1'b1);
    wait_done(found, bc);
    expect_result("t4a", 8'h00, 1'b1, 1'b0);
    start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(found, bc);
    check("t4b_sum", sum, 8'h07);

    // 5: start during RUN is ignored
    issue(8'h10, 8'h20, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done(found, bc);
    check("t5_sum", sum, 8'h30);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t5_no_extra_done", extra, 0);

    // 6: asynchronous reset mid-operation
    issue(8'hF0, 8'h0F, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_sum",  sum,  0);
    check("t6_rst_cout", cout, 0);
    check("t6_rst_ovf",  ovf,  0);
    @(posedge clk); #3 rst_n = 1'b1;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("t6_no_done_after_reset", extra, 0);
    issue(8'h01, 8'h02, 1'b0);
    wait_done(found, bc);
    expect_result("t6b", 8'h03, 1'b0, 1'b0);

    // Randomized operations, some back-to-back, some with spurious starts mid-run
    for (int n = 0; n < 60; n++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #2;
        start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        @(posedge clk); #2;
        start = 1'b0;
      end
      wait_done(found, bc);
      if ($urandom_range(0, 2) == 0) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        @(posedge clk); #2;
        start = 1'b0;
        wait_done(found, bc);
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
